// File: rtl/ides_word_aligner.sv
// Word aligner for the IDES8 parallel output. Compares each word against
// the training pattern, issues one-cycle bit-slip pulses on CALIB until the
// pattern appears, and declares lock after a run of consecutive matches.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SETTLE | let the deserializer output settle after reset/relock/slip
// CHECK  | compare din against TRAIN_PATTERN while train_en is high
// SLIP   | calib high for exactly this cycle
// LOCKED | alignment achieved, din no longer compared
module ides_word_aligner #(
    parameter int                WIDTH         = 8,
    parameter logic [WIDTH-1:0]  TRAIN_PATTERN = 8'h5C,
    parameter int                MATCH_CNT     = 16,
    parameter int                SETTLE_CYC    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             train_en,
    input  logic             relock,
    output logic             calib,
    output logic             locked,
    output logic [3:0]       slip_cnt,
    output logic             align_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld
);

    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_CNT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC);
    // Slip count at which a full rotation has been exhausted.
    localparam logic [4:0]    ERR_AT      = (WIDTH > 15) ? 5'd16 : 5'(WIDTH);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_SLIP   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    logic [1:0]    state;
    logic [MW-1:0] match_cnt;
    logic [SW-1:0] settle_cnt;
    logic [MW-1:0] match_nxt;
    logic [SW-1:0] settle_nxt;

    assign match_nxt  = match_cnt + MW'(1);
    assign settle_nxt = settle_cnt + SW'(1);

    // Data path: din registered once, independent of alignment state.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= din;
        end
    end

    // Valid flag follows locked by one cycle so it lines up with dout.
    always_ff @(posedge clk) begin
        if (rst || relock) begin
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= locked;
        end
    end

    // Alignment FSM with settle/match counters and slip bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || relock) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            slip_cnt   <= '0;
            calib      <= 1'b0;
            locked     <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            calib <= 1'b0;
            case (state)
                ST_SETTLE: begin
                    if (settle_nxt == SETTLE_LAST) begin
                        state      <= ST_CHECK;
                        settle_cnt <= '0;
                        match_cnt  <= '0;
                    end else begin
                        settle_cnt <= settle_nxt;
                    end
                end
                ST_CHECK: begin
                    if (train_en) begin
                        if (din == TRAIN_PATTERN) begin
                            match_cnt <= match_nxt;
                            if (match_nxt == MATCH_LAST) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            // Slip bookkeeping is registered on entry so that
                            // slip_cnt and align_err are already valid while
                            // calib is high.
                            state <= ST_SLIP;
                            calib <= 1'b1;
                            if (slip_cnt != 4'hF) begin
                                slip_cnt <= slip_cnt + 4'd1;
                            end
                            if ({1'b0, slip_cnt} >= ERR_AT) begin
                                align_err <= 1'b1;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_LOCKED: begin
                    locked <= 1'b1;
                end
                default: begin
                    state <= ST_SETTLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ides_word_aligner.sv
// Testbench for ides_word_aligner: directed scenarios with randomized word
// offsets and reset data, checked against timing derived from the
// settle/match/slip rules (lock edge = SETTLE + MATCH + (SETTLE+2)*slips).
module tb_ides_word_aligner;

    localparam int          SC = 4;
    localparam int          MC = 16;
    localparam logic [7:0]  TP = 8'h5C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       train_en = 1'b0;
    logic       relock = 1'b0;
    logic       calib;
    logic       locked;
    logic [3:0] slip_cnt;
    logic       align_err;
    logic [7:0] dout;
    logic       dout_vld;

    int checks = 0;
    int errors = 0;

    int calib_q[$];
    int lock_e;
    int vld_e;
    int err_e;
    int dout_bad;
    int min_gap;
    bit consec;

    always #5 clk = ~clk;

    ides_word_aligner #(
        .WIDTH(8), .TRAIN_PATTERN(TP), .MATCH_CNT(MC), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .train_en(train_en), .relock(relock),
        .calib(calib), .locked(locked), .slip_cnt(slip_cnt), .align_err(align_err),
        .dout(dout), .dout_vld(dout_vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
        return r;
    endfunction

    function automatic int exp_lock(input int slips);
        return SC + MC + (SC + 2) * slips;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        relock = 1'b0;
        train_en = 1'b0;
        repeat (3) begin
            din = 8'($urandom);
            tick();
        end
        rst = 1'b0;
    endtask

    // Runs n edges (edge 1 = first edge after the call) and records events.
    // A sensor bit-slip model rotates din left once per observed calib pulse.
    task automatic observe(input int n, input bit rotate, input int gap_lo,
                           input int gap_len, input int relock_e);
        logic       prev_calib;
        logic [7:0] prev_din;
        calib_q.delete();
        lock_e = -1; vld_e = -1; err_e = -1;
        dout_bad = 0; min_gap = 1000; consec = 0;
        prev_calib = calib;
        for (int e = 1; e <= n; e++) begin
            train_en = !(e >= gap_lo && e < gap_lo + gap_len);
            relock   = (e == relock_e);
            prev_din = din;
            tick();
            relock = 1'b0;
            if (dout !== prev_din) dout_bad++;
            if (calib === 1'b1) begin
                if (prev_calib === 1'b1) consec = 1;
                if (calib_q.size() > 0 && (e - calib_q[$]) < min_gap) min_gap = e - calib_q[$];
                calib_q.push_back(e);
                if (rotate) din = {din[6:0], din[7]};
            end
            prev_calib = calib;
            if (locked === 1'b1 && lock_e < 0) lock_e = e;
            if (dout_vld === 1'b1 && vld_e < 0) vld_e = e;
            if (align_err === 1'b1 && err_e < 0) err_e = e;
        end
    endtask

    task automatic check_rotation(input string tag, input int r);
        do_reset();
        din = rotr(TP, r);
        observe(exp_lock(r) + 3, 1'b1, 0, 0, 0);
        chk({tag, "_pulses"}, calib_q.size(), r);
        chk({tag, "_lock_edge"}, lock_e, exp_lock(r));
        chk({tag, "_vld_edge"}, vld_e, exp_lock(r) + 1);
        chk({tag, "_slip_cnt"}, slip_cnt, r);
        chk({tag, "_align_err"}, align_err, 0);
        chk({tag, "_consec"}, consec, 0);
        if (r > 0) chk({tag, "_first_pulse"}, calib_q[0], SC + 1);
        if (r > 1) chk({tag, "_spacing"}, min_gap, SC + 2);
        chk({tag, "_dout"}, dout_bad, 0);
    endtask

    initial begin
        // Reset with random din: everything zero.
        do_reset();
        chk("rst_calib", calib, 0);
        chk("rst_locked", locked, 0);
        chk("rst_slip", slip_cnt, 0);
        chk("rst_err", align_err, 0);
        chk("rst_dout", dout, 0);
        chk("rst_vld", dout_vld, 0);

        // Immediate lock from release.
        din = TP;
        observe(24, 1'b0, 0, 0, 0);
        chk("imm_lock_edge", lock_e, SC + MC);
        chk("imm_vld_edge", vld_e, SC + MC + 1);
        chk("imm_no_calib", calib_q.size(), 0);
        chk("imm_slip", slip_cnt, 0);
        chk("imm_dout", dout_bad, 0);

        // Rotated input, offset 3, then random offsets.
        check_rotation("rot3", 3);

        // Relock while locked with slips recorded.
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock_locked", locked, 0);
        chk("relock_vld", dout_vld, 0);
        chk("relock_slip", slip_cnt, 0);
        chk("relock_calib", calib, 0);
        observe(22, 1'b0, 0, 0, 0);
        chk("relock_lock_edge", lock_e, SC + MC);
        chk("relock_no_calib", calib_q.size(), 0);

        for (int k = 0; k < 3; k++) begin
            check_rotation($sformatf("rnd%0d", k), int'($urandom_range(0, 7)));
        end

        // No pattern: align_err on the 9th pulse, slip_cnt saturates.
        do_reset();
        din = 8'hFF;
        observe(SC + 1 + (SC + 2) * 16, 1'b1, 0, 0, 0);
        chk("nopat_pulses", calib_q.size(), 17);
        chk("nopat_err_edge", err_e, SC + 1 + (SC + 2) * 8);
        chk("nopat_err_on_9th", calib_q[8], err_e);
        chk("nopat_slip_sat", slip_cnt, 15);
        chk("nopat_locked", lock_e, -1);
        chk("nopat_consec", consec, 0);
        chk("nopat_spacing", min_gap, SC + 2);

        // Relock clears the sticky error and slip count.
        din = TP;
        relock = 1'b1;
        tick();
        relock = 1'b0;
        chk("relock2_err", align_err, 0);
        chk("relock2_slip", slip_cnt, 0);
        observe(22, 1'b0, 0, 0, 0);
        chk("relock2_lock_edge", lock_e, SC + MC);

        // train_en gap of 5 cycles after 10 matches.
        do_reset();
        din = TP;
        observe(30, 1'b0, SC + 11, 5, 0);
        chk("gap_no_calib", calib_q.size(), 0);
        chk("gap_lock_edge", lock_e, SC + MC + 5);

        // Relock on the edge that would complete the lock.
        do_reset();
        din = TP;
        observe(45, 1'b0, 0, 0, SC + MC);
        chk("relock_win_lock_edge", lock_e, 2 * (SC + MC));
        chk("relock_win_vld_edge", vld_e, 2 * (SC + MC) + 1);

        // relock together with rst behaves as reset.
        rst = 1'b1;
        relock = 1'b1;
        tick();
        rst = 1'b0;
        relock = 1'b0;
        chk("rst_relock_locked", locked, 0);
        chk("rst_relock_dout", dout, 0);
        observe(22, 1'b0, 0, 0, 0);
        chk("rst_relock_lock_edge", lock_e, SC + MC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ides_word_aligner.md
# ides_word_aligner

Word-alignment controller in the divided (parallel) clock domain behind the 1:4 clock divider and the IDES8 deserializer on the sensor LVDS input. It compares each deserialized 8-bit word against a fixed training pattern, pulses the deserializer `CALIB` (bit-slip) input until the pattern appears, and declares lock after a run of consecutive matches. Aligned words are then passed downstream with a valid flag.

## Interface
Parameters:
- `WIDTH`, default 8: deserialized word width; it is also the number of slips in one full rotation.
- `TRAIN_PATTERN`, default 8'h5C: training word sent by the sensor while in training mode.
- `MATCH_CNT`, default 16: number of consecutive matches required for lock.
- `SETTLE_CYC`, default 4: `clk` cycles to wait after reset, relock or a slip before comparing.

Ports:
- `clk`  in  1  divided clock (CLKDIV output), sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  IDES parallel output, sampled every `clk`.
- `train_en`  in  1  high while the sensor is sending `TRAIN_PATTERN`.
- `relock`  in  1  single-cycle request to drop lock and re-align.
- `calib`  out  1  bit-slip pulse to IDES `CALIB`.
- `locked`  out  1  alignment achieved.
- `slip_cnt`  out  4  slips issued since reset or relock; saturates at 15.
- `align_err`  out  1  sticky flag: no lock within one full rotation.
- `dout`  out  WIDTH  registered `din`.
- `dout_vld`  out  1  `dout` is aligned data.

## Operation
- States: SETTLE, CHECK, SLIP, LOCKED. All outputs are registered.
- Reset values: state SETTLE; all counters 0; `calib`, `locked`, `align_err`, `dout_vld` = 0; `dout` = 0.
- SETTLE
  - Settle counter increments each cycle.
  - On the cycle it reaches `SETTLE_CYC`, go to CHECK and clear the match counter.
- CHECK
  - `train_en` = 0: hold. No compare, counters frozen, no `calib`.
  - `train_en` = 1 and `din == TRAIN_PATTERN`: match counter +1. When it reaches `MATCH_CNT`, go to LOCKED and set `locked` = 1.
  - `train_en` = 1 and mismatch: go to SLIP.
- SLIP (exactly one cycle)
  - `calib` = 1 for this cycle only.
  - `slip_cnt` +1, saturating at 15.
  - If `slip_cnt` ≥ `WIDTH` before the increment, set `align_err`. It stays set until reset or relock.
  - Next state is SETTLE. The search continues after an error; it never gives up.
- LOCKED
  - `locked` = 1; `din` is no longer compared.
  - `dout_vld` = `locked` delayed by one cycle, so it aligns with `dout`.
- `relock` (any state)
  - Next edge: go to SETTLE; `locked`, `dout_vld` and `align_err` = 0; `slip_cnt`, match counter and settle counter cleared.
  - `calib` is forced to 0.
- Priority: `rst` > `relock` > state logic. A `relock` on the cycle the lock would complete wins; `locked` stays 0.
- Match counter width is clog2(`MATCH_CNT`+1). Settle counter width is clog2(`SETTLE_CYC`+1).

## Timing
- `dout` = `din` with 1-cycle latency, updated every cycle regardless of state.
- Cycle numbering: edge 1 is the first edge with `rst` = 0.
- Lock latency with no slips: `locked` is high after edge `SETTLE_CYC` + `MATCH_CNT` (20 with defaults). `dout_vld` is high one edge later.
- Each slip costs 1 + `SETTLE_CYC` cycles, plus at least one CHECK cycle.
- Minimum spacing between `calib` rising edges is `SETTLE_CYC` + 2 = 6 cycles.
- `calib` is never high on two consecutive cycles.
- `relock` takes effect on the next edge. `locked` falls at that edge.

## Test plan
- Reset: hold `rst` 3 cycles with random `din` -> all outputs 0, no `calib`; 2 cycles after release, still `locked` = 0.
- Immediate lock: `din` = 8'h5C, `train_en` = 1 from release -> `locked` high after edge 20, `dout_vld` high after edge 21, `slip_cnt` = 0, `calib` never high.
- Rotated input: model rotates `din` left by one bit per `calib` pulse, starting offset 3 -> exactly 3 one-cycle `calib` pulses at least 6 cycles apart, `slip_cnt` = 3, `locked` = 1, `align_err` = 0.
- No pattern: `din` constant 8'hFF -> `calib` keeps pulsing; `align_err` set in the SLIP cycle of the 9th pulse; `slip_cnt` saturates at 15.
- `train_en` gap: drop `train_en` for 5 cycles after 10 matches -> no `calib`; lock completes after 6 more matching cycles.
- Relock: pulse `relock` while LOCKED -> after the next edge `locked` = `dout_vld` = `slip_cnt` = 0; re-lock occurs 20 cycles later. A `relock` together with `rst` behaves as reset.
